// File: rtl/sap_core.sv
// Accumulator CPU with internal RAM, host load port and a FETCH/DECODE/EXEC microsequencer.
// Optional single-step input enabled by defining SAP_STEP_EN.
module sap_core #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clock,
  input  logic                 bReset,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_BITS-1:0] load_data,
  input  logic                 start,
`ifdef SAP_STEP_EN
  input  logic                 step,
`endif
  output logic [DATA_BITS-1:0] out,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 halted,
  output logic [ADDR_BITS-1:0] pc
);

  localparam int unsigned DEPTH   = 2 ** ADDR_BITS;
  localparam int unsigned OP_BITS = 4;

  localparam logic [OP_BITS-1:0] OP_LDA = 4'h1;
  localparam logic [OP_BITS-1:0] OP_ADD = 4'h2;
  localparam logic [OP_BITS-1:0] OP_SUB = 4'h3;
  localparam logic [OP_BITS-1:0] OP_STA = 4'h4;
  localparam logic [OP_BITS-1:0] OP_LDI = 4'h5;
  localparam logic [OP_BITS-1:0] OP_JMP = 4'h6;
  localparam logic [OP_BITS-1:0] OP_JC  = 4'h7;
  localparam logic [OP_BITS-1:0] OP_JZ  = 4'h8;
  localparam logic [OP_BITS-1:0] OP_OUT = 4'hE;
  localparam logic [OP_BITS-1:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t                 state, state_n;
  logic [DATA_BITS-1:0]   mem [DEPTH];
  logic [DATA_BITS-1:0]   a, a_n, b, b_n, out_n;
  logic [OP_BITS-1:0]     ir_op, ir_op_n;
  logic [ADDR_BITS-1:0]   ir_arg, ir_arg_n, pc_n;
  logic                   carry, carry_n, zero, zero_n, out_valid_n;
  logic                   mem_we;
  logic [ADDR_BITS-1:0]   mem_waddr;
  logic [DATA_BITS-1:0]   mem_wdata;
  logic [DATA_BITS:0]     sum;

  // State register
  always_ff @(posedge clock or negedge bReset) begin
    if (!bReset) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state, datapath next values and RAM write request
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    a_n         = a;
    b_n         = b;
    ir_op_n     = ir_op;
    ir_arg_n    = ir_arg;
    out_n       = out;
    carry_n     = carry;
    zero_n      = zero;
    out_valid_n = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = load_addr;
    mem_wdata   = load_data;
    sum         = '0;
    case (state)
      IDLE, HALT: begin
        mem_we = load_en;
        if (start) begin
          pc_n    = '0;
          a_n     = '0;
          b_n     = '0;
          carry_n = 1'b0;
          zero_n  = 1'b0;
          state_n = FETCH;
        end
      end
      FETCH: begin
`ifdef SAP_STEP_EN
        if (step) begin
`else
        begin
`endif
          ir_op_n  = mem[pc][DATA_BITS-1 -: OP_BITS];
          ir_arg_n = mem[pc][ADDR_BITS-1:0];
          pc_n     = pc + ADDR_BITS'(1);
          state_n  = DECODE;
        end
      end
      DECODE: begin
        b_n     = mem[ir_arg];
        state_n = (ir_op == OP_HLT) ? HALT : EXEC;
      end
      EXEC: begin
        state_n = FETCH;
        case (ir_op)
          OP_LDA: a_n = b;
          OP_ADD, OP_SUB: begin
            if (ir_op == OP_ADD) sum = {1'b0, a} + {1'b0, b};
            else                 sum = {1'b0, a} + {1'b0, ~b} + (DATA_BITS+1)'(1);
            a_n     = sum[DATA_BITS-1:0];
            carry_n = sum[DATA_BITS];
            zero_n  = (sum[DATA_BITS-1:0] == '0);
          end
          OP_STA: begin
            mem_we    = 1'b1;
            mem_waddr = ir_arg;
            mem_wdata = a;
          end
          OP_LDI: a_n = DATA_BITS'(ir_arg);
          OP_JMP: pc_n = ir_arg;
          OP_JC:  if (carry) pc_n = ir_arg;
          OP_JZ:  if (zero)  pc_n = ir_arg;
          OP_OUT: begin
            out_n       = a;
            out_valid_n = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath and status registers
  always_ff @(posedge clock or negedge bReset) begin
    if (!bReset) begin
      pc        <= '0;
      a         <= '0;
      b         <= '0;
      ir_op     <= '0;
      ir_arg    <= '0;
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      pc        <= pc_n;
      a         <= a_n;
      b         <= b_n;
      ir_op     <= ir_op_n;
      ir_arg    <= ir_arg_n;
      out       <= out_n;
      carry     <= carry_n;
      zero      <= zero_n;
      out_valid <= out_valid_n;
      busy      <= (state_n == FETCH) || (state_n == DECODE) || (state_n == EXEC);
      halted    <= (state_n == HALT);
    end
  end

  // Program/data RAM keeps its contents across reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule
